// File: rtl/inertial_integrator.sv
// rtl/inertial_integrator.sv - gyro offset calibration and pitch integration for balance_cntrl
//
// Purpose: averages 2^CAL_LOG2 raw gyro samples after reset to find the rate
// offset. Afterwards every vld sample is offset-compensated, saturated to 16 bits
// and integrated into a 27-bit pitch accumulator. The optional Z-accel fusion
// nudges the integral by +/-1024 per sample towards the accel pitch estimate.
//
// Configuration macro: INERT_FUSION_EN (defined -> accel fusion built in).
//
// Parameters:
//   fast_sim    1 -> 16 calibration samples, 0 -> 256 calibration samples
//   AZ_OFFSET   signed Z-accel zero offset subtracted before fusion
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   vld          in   one-cycle strobe, ptch_rt_raw/AZ valid
//   ptch_rt_raw  in   signed raw gyro pitch rate
//   AZ           in   signed raw Z acceleration
//   ptch         out  signed pitch estimate, ptch_int[26:11]
//   ptch_rt      out  signed offset-compensated pitch rate
//   ptch_vld     out  one-cycle strobe, ptch/ptch_rt updated
//   cal_done     out  high once the gyro offset has been captured

module inertial_integrator #(
   parameter bit          fast_sim  = 1'b1,
   parameter logic [15:0] AZ_OFFSET = 16'h00A0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vld,
   input  logic [15:0] ptch_rt_raw,
   input  logic [15:0] AZ,
   output logic [15:0] ptch,
   output logic [15:0] ptch_rt,
   output logic        ptch_vld,
   output logic        cal_done
);

   localparam int         CAL_LOG2 = fast_sim ? 4 : 8;
   localparam logic [8:0] CAL_N    = 9'(1 << CAL_LOG2);

   localparam logic signed [28:0] INT_MAX = 29'sd67108863;   //  2^26 - 1
   localparam logic signed [28:0] INT_MIN = -29'sd67108864;  // -2^26

   typedef enum logic {CAL, RUN} state_t;

   state_t              state;
   logic signed [23:0]  cal_sum;
   logic        [8:0]   cal_cnt;
   logic signed [15:0]  offset;
   logic signed [26:0]  ptch_int;

   logic signed [23:0]  cal_next;
   logic signed [16:0]  diff;
   logic signed [15:0]  comp;
   logic signed [28:0]  fus;
   logic signed [28:0]  int_sum;
   logic signed [26:0]  int_next;

`ifdef INERT_FUSION_EN
   logic        [15:0]  az_c;
   logic signed [25:0]  prod;
   logic signed [15:0]  ptch_acc;
`endif

   assign ptch = ptch_int[26:11];

   always_comb begin
      cal_next = cal_sum + 24'(signed'(ptch_rt_raw));

      // 17-bit difference cannot overflow; clamp back into 16 bits
      diff = 17'(signed'(ptch_rt_raw)) - 17'(offset);
      if (diff > 17'sd32767)
         comp = 16'sh7FFF;
      else if (diff < -17'sd32768)
         comp = 16'sh8000;
      else
         comp = diff[15:0];

`ifdef INERT_FUSION_EN
      az_c     = AZ - AZ_OFFSET;
      prod     = 26'(signed'(az_c)) * 26'sd327;
      // arithmetic shift by 13 then truncate == sign-extended prod[25:13]
      ptch_acc = 16'(prod >>> 13);
      fus      = (ptch_acc > signed'(ptch)) ? 29'sd1024 : -29'sd1024;
`else
      // AZ has no function without fusion; folded in as a constant zero so
      // the port and offset parameter remain referenced
      fus = 29'((AZ ^ AZ_OFFSET) & ~(AZ ^ AZ_OFFSET));
`endif

      // 29 bits hold any 27-bit value minus a 16-bit value plus 1024
      int_sum = 29'(ptch_int) - 29'(comp) + fus;
      if (int_sum > INT_MAX)
         int_next = INT_MAX[26:0];
      else if (int_sum < INT_MIN)
         int_next = INT_MIN[26:0];
      else
         int_next = int_sum[26:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= CAL;
         cal_sum  <= '0;
         cal_cnt  <= '0;
         offset   <= '0;
         ptch_int <= '0;
         ptch_rt  <= '0;
         ptch_vld <= 1'b0;
         cal_done <= 1'b0;
      end else begin
         ptch_vld <= 1'b0;
         case (state)
            CAL: begin
               if (vld) begin
                  cal_sum <= cal_next;
                  cal_cnt <= cal_cnt + 9'd1;
                  if (cal_cnt + 9'd1 == CAL_N) begin
                     offset   <= 16'(cal_next >>> CAL_LOG2);
                     state    <= RUN;
                     cal_done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (vld) begin
                  ptch_rt  <= comp;
                  ptch_int <= int_next;
                  ptch_vld <= 1'b1;
               end
            end
            default: state <= CAL;
         endcase
      end
   end

endmodule

// File: tb/tb_inertial_integrator.sv
// tb/tb_inertial_integrator.sv - directed self-checking bench for inertial_integrator

module tb_inertial_integrator;

   localparam logic [15:0] AZ_OFF = 16'h00A0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vld;
   logic [15:0] ptch_rt_raw;
   logic [15:0] AZ;
   logic [15:0] ptch;
   logic [15:0] ptch_rt;
   logic        ptch_vld;
   logic        cal_done;

   int total = 0;
   int bad   = 0;
   int pv_cnt = 0;

   inertial_integrator #(.fast_sim(1'b1), .AZ_OFFSET(AZ_OFF)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .vld(vld),
      .ptch_rt_raw(ptch_rt_raw),
      .AZ(AZ),
      .ptch(ptch),
      .ptch_rt(ptch_rt),
      .ptch_vld(ptch_vld),
      .cal_done(cal_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (ptch_vld) pv_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [15:0] raw, input logic [15:0] az);
      @(negedge clk);
      vld = 1'b1; ptch_rt_raw = raw; AZ = az;
      @(negedge clk);
      vld = 1'b0;
   endtask

   task automatic burst(input int n, input logic [15:0] raw, input logic [15:0] az);
      @(negedge clk);
      vld = 1'b1; ptch_rt_raw = raw; AZ = az;
      repeat (n) @(negedge clk);
      vld = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic calibrate(input logic [15:0] raw);
      repeat (16) send(raw, AZ_OFF);
   endtask

   initial begin
      rst_n = 1'b0; vld = 1'b0; ptch_rt_raw = '0; AZ = '0;

      // reset with random stimulus
      repeat (6) begin
         @(negedge clk);
         vld = 1'($urandom); ptch_rt_raw = 16'($urandom); AZ = 16'($urandom);
      end
      check("rst_ptch", {16'h0, ptch}, 32'h0);
      check("rst_ptch_rt", {16'h0, ptch_rt}, 32'h0);
      check("rst_ptch_vld", {31'h0, ptch_vld}, 32'h0);
      check("rst_cal_done", {31'h0, cal_done}, 32'h0);
      @(negedge clk);
      vld = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      pv_cnt = 0;

      // calibration: 15 samples not enough, 16th completes
      repeat (15) send(16'h0040, AZ_OFF);
      check("cal15_done", {31'h0, cal_done}, 32'h0);
      send(16'h0040, AZ_OFF);
      check("cal16_done", {31'h0, cal_done}, 32'h1);
      check("cal16_no_vld", {31'h0, ptch_vld}, 32'h0);
      repeat (2) @(negedge clk);
      check("cal_no_vld_cnt", pv_cnt, 32'd0);

      // first RUN sample
      send(16'h0040, AZ_OFF);
      check("run1_ptch_rt", {16'h0, ptch_rt}, 32'h0);
      check("run1_vld", {31'h0, ptch_vld}, 32'h1);
`ifdef INERT_FUSION_EN
      check("run1_ptch", {16'h0, ptch}, 32'hFFFF);
`else
      check("run1_ptch", {16'h0, ptch}, 32'h0);
`endif
      @(negedge clk);
      check("run1_vld_drop", {31'h0, ptch_vld}, 32'h0);

      // integration: 100 back-to-back samples of comp=0x800
      do_reset();
      calibrate(16'h0040);
      pv_cnt = 0;
      burst(100, 16'h0840, AZ_OFF);
      check("int_ptch_rt", {16'h0, ptch_rt}, 32'h0800);
`ifdef INERT_FUSION_EN
      check("int_ptch", {16'h0, ptch}, 32'h0000FFCD);   // -51
`else
      check("int_ptch", {16'h0, ptch}, 32'h0000FF9C);   // -100
`endif
      repeat (2) @(negedge clk);
      check("int_vld_cnt", pv_cnt, 32'd100);

      // saturation of comp and of the integrator
      do_reset();
      calibrate(16'h0040);
      send(16'h8000, AZ_OFF);
      check("sat_ptch_rt", {16'h0, ptch_rt}, 32'h8000);
      burst(2200, 16'h8000, AZ_OFF);
      check("sat_ptch", {16'h0, ptch}, 32'h7FFF);
      send(16'h8000, AZ_OFF);
      check("sat_no_wrap", {16'h0, ptch}, 32'h7FFF);

      // fusion direction: accel pitch above current pitch, comp=0
      do_reset();
      calibrate(16'h0040);
      send(16'h0040, AZ_OFF + 16'h1000);
      send(16'h0040, AZ_OFF + 16'h1000);
      check("fus_ptch_rt", {16'h0, ptch_rt}, 32'h0);
`ifdef INERT_FUSION_EN
      check("fus_ptch", {16'h0, ptch}, 32'h0001);        // ptch_int = 2048
`else
      check("fus_ptch", {16'h0, ptch}, 32'h0000);
`endif

      // reset mid-calibration discards earlier samples and count
      do_reset();
      repeat (8) send(16'h1000, AZ_OFF);
      do_reset();
      check("midrst_done", {31'h0, cal_done}, 32'h0);
      repeat (15) send(16'h0020, AZ_OFF);
      check("midrst_15", {31'h0, cal_done}, 32'h0);
      send(16'h0020, AZ_OFF);
      check("midrst_16", {31'h0, cal_done}, 32'h1);
      send(16'h0020, AZ_OFF);
      check("midrst_offset", {16'h0, ptch_rt}, 32'h0);

      // arithmetic (floor) averaging: sum -1 >>> 4 = -1
      do_reset();
      repeat (15) send(16'h0000, AZ_OFF);
      send(16'hFFFF, AZ_OFF);
      send(16'h0000, AZ_OFF);
      check("neg_offset", {16'h0, ptch_rt}, 32'h0001);
      send(16'h7FFF, AZ_OFF);
      check("pos_sat_comp", {16'h0, ptch_rt}, 32'h7FFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inertial_integrator.md
# inertial_integrator

Producer side of the balance controller's `ptch`/`ptch_rt`/`vld` input interface. It takes raw gyro pitch-rate and Z-accel samples from the inertial SPI interface, calibrates the gyro offset at power-on, and integrates the compensated rate into pitch. Output is a pitch estimate with accelerometer fusion, plus a one-cycle valid strobe for `balance_cntrl`.

## Interface
- `fast_sim`, 1, selects calibration length: 1 → 16 samples (CAL_LOG2=4), 0 → 256 samples (CAL_LOG2=8)
- `AZ_OFFSET`, 16'h00A0, signed Z-accel zero offset subtracted before fusion
- `clk`  in  1  system clock; one clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `vld`  in  1  one-cycle strobe: `ptch_rt_raw`/`AZ` valid this cycle
- `ptch_rt_raw`  in  16  signed raw gyro pitch rate
- `AZ`  in  16  signed raw Z acceleration
- `ptch`  out  16  signed pitch estimate (ptch_int[26:11])
- `ptch_rt`  out  16  signed offset-compensated pitch rate, registered
- `ptch_vld`  out  1  one-cycle strobe: `ptch`/`ptch_rt` updated
- `cal_done`  out  1  high once gyro offset is captured

## Operation
- States: CAL (reset state), RUN. No other states; RUN is held until reset.
- CAL: on each `vld`, add sign-extended `ptch_rt_raw` into 24-bit signed `cal_sum`; increment 9-bit `cal_cnt`. On the vld that makes `cal_cnt` == 2^CAL_LOG2: `offset <= (cal_sum + sample) >>> CAL_LOG2` (arithmetic), state → RUN, `cal_done` ← 1. No `ptch_vld` and no output updates in CAL.
- RUN, on each `vld`:
  - `comp = ptch_rt_raw - offset` in 17 bits, saturated to [-32768, 32767]; `ptch_rt <= comp`.
  - `az_c = AZ - AZ_OFFSET` (16-bit wrap); `prod = az_c * 327` (signed, 26-bit); `ptch_acc = sign-extend(prod[25:13])` to 16 bits.
  - `fus = (ptch_acc > ptch) ? +1024 : -1024`; compare against current `ptch` (pre-update).
  - `ptch_int <= sat27(ptch_int - sext27(comp) + fus)`, saturating at the 27-bit signed limits, never wrapping.
  - `ptch_vld <= 1` for exactly one cycle.
- Back-to-back `vld` (every cycle) is legal; each sample is processed independently.

## Timing
- Reset values: `ptch`=0, `ptch_rt`=0, `ptch_vld`=0, `cal_done`=0, `ptch_int`=0, `offset`=0, `cal_sum`=0, `cal_cnt`=0, state=CAL.
- Latency: `vld` in cycle k → `ptch_rt`, `ptch`, `ptch_vld`=1 in cycle k+1; `ptch_vld` low in k+2 unless `vld` in k+1.
- Final calibration `vld` in cycle k → `cal_done`=1 at k+1. The next `vld` (≥k+1) is the first RUN sample. That final calibration sample produces no output.
- `rst_n` asserted mid-calibration or mid-run: all state returns to reset values immediately, and the full calibration count restarts.

## Configuration
- `INERT_FUSION_EN` defined: accel fusion active as above.
- Undefined: `fus` = 0 and the `AZ` multiplier is not built. Pitch is pure gyro integration: `ptch_int <= sat27(ptch_int - sext27(comp))`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `ptch`=0, `ptch_rt`=0, `ptch_vld`=0, `cal_done`=0; then 15 `vld` pulses → `cal_done` still 0, `ptch_vld` never 1.
- Calibration (fast_sim=1): 16 `vld` with raw=16'h0040 → `cal_done`=1 one cycle after the 16th. Next `vld` with raw=16'h0040 and AZ=AZ_OFFSET → `ptch_rt`=0, `ptch_vld` pulses. With fusion, `ptch`=16'hFFFF (`ptch_int`=-1024); without fusion, `ptch`=0.
- Integration (no fusion): offset 0x40, then 100 `vld` with raw=16'h0840 → `ptch_rt`=16'h0800 and `ptch`=-100 (16'hFF9C) after the 100th.
- Saturation: offset 0x40, raw=16'h8000 → `ptch_rt`=16'h8000. Drive raw=16'h8000 continuously → `ptch_int` clamps at 27'h3FFFFFF and `ptch` sticks at 16'h7FFF, no wrap.
- Fusion direction: `ptch`=0, AZ=AZ_OFFSET+16'h1000 → `ptch_acc`=163 > 0, so `ptch_int` increases by 1024 per `vld` with `comp`=0.
- Reset mid-calibration: 8 `vld`, pulse `rst_n` low, 15 more `vld` → `cal_done`=0; the 16th post-reset `vld` → `cal_done`=1 with offset computed from post-reset samples only.
